// File: rtl/hdlc_pkg.sv
// ============================================================================
// Module   : hdlc_pkg
// Purpose  : HDLC octet constants, framer state encoding and CRC-16/X.25 step,
//            shared by the framer and the deframer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package hdlc_pkg;

    localparam logic [7:0]  HDLC_FLAG    = 8'h7E;
    localparam logic [7:0]  HDLC_ESC     = 8'h7D;
    localparam logic [7:0]  HDLC_ESC_XOR = 8'h20;
    localparam logic [15:0] CRC16_POLY   = 16'h8408;
    localparam logic [15:0] CRC16_INIT   = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PAYLOAD = 3'd1,
        ST_FCS_LO  = 3'd2,
        ST_FCS_HI  = 3'd3,
        ST_CLOSE   = 3'd4,
        ST_ABORT   = 3'd5
    } hdlc_state_e;

    // One reflected CRC-16 step over a full octet, LSB first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc,
                                               input logic [7:0]  b);
        logic [15:0] c;
        c = crc ^ {8'h00, b};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC16_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/hdlc_crc16.sv
// ============================================================================
// Module   : hdlc_crc16
// Purpose  : CRC-16/X.25 accumulator; init restarts, update folds in one byte.
// Revision : 1.0
// ============================================================================
`default_nettype none

module hdlc_crc16
    import hdlc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        init_i,
    input  logic        update_i,
    input  logic [7:0]  byte_i,
    output logic [15:0] crc_o
);

    logic [15:0] crc_q;
    logic [15:0] crc_d;

    // init together with update means "start a new frame with this byte".
    always_comb begin
        crc_d = crc_q;
        if (update_i) begin
            crc_d = crc16_byte(init_i ? CRC16_INIT : crc_q, byte_i);
        end else if (init_i) begin
            crc_d = CRC16_INIT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            crc_q <= CRC16_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

`default_nettype wire

// File: rtl/hdlc_framer.sv
// ============================================================================
// Module   : hdlc_framer
// Purpose  : Transmit HDLC framer: flags, byte stuffing, FCS append, abort.
//            Build option HDLC_FCS_EN adds the CRC-16 FCS; without it frames
//            close directly after the payload.
// Revision : 1.0
// ============================================================================
`default_nettype none

module hdlc_framer
    import hdlc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       valid_in,
    input  logic       sop_in,
    input  logic       eop_in,
    input  logic [7:0] data_in,
    output logic       ready_in,
    output logic [7:0] data_fr,
    output logic       underrun
);

    hdlc_state_e state_q;
    logic [7:0]  hold_q;
    logic        hold_eop_q;
    logic        esc_pend_q;
    logic [7:0]  data_fr_q;
    logic        underrun_q;

    logic [15:0] crc;
    logic [7:0]  raw_byte;
    logic [7:0]  emit_byte;
    logic        escable;
    logic        need_esc;
    logic        final_form;
    logic        accept;

`ifdef HDLC_FCS_EN
    logic crc_init;
    logic crc_update;

    // A sop restarts the CRC; only bytes that stay in the frame are folded in.
    assign crc_init   = accept && sop_in;
    assign crc_update = accept && ((state_q == ST_IDLE) ? sop_in : !sop_in);

    hdlc_crc16 u_crc16 (
        .clk      (clk),
        .rst      (rst),
        .init_i   (crc_init),
        .update_i (crc_update),
        .byte_i   (data_in),
        .crc_o    (crc)
    );
`else
    assign crc = CRC16_INIT;
`endif

    always_comb begin
        raw_byte = HDLC_FLAG;
        escable  = 1'b0;
        case (state_q)
            ST_IDLE:    raw_byte = HDLC_FLAG;
            ST_PAYLOAD: begin
                raw_byte = hold_q;
                escable  = 1'b1;
            end
            ST_FCS_LO:  begin
                raw_byte = ~crc[7:0];
                escable  = 1'b1;
            end
            ST_FCS_HI:  begin
                raw_byte = ~crc[15:8];
                escable  = 1'b1;
            end
            ST_CLOSE:   raw_byte = HDLC_FLAG;
            ST_ABORT:   raw_byte = HDLC_ESC;
            default:    raw_byte = HDLC_FLAG;
        endcase

        // Flags and the abort pair are never stuffed.
        need_esc   = escable && !esc_pend_q &&
                     ((raw_byte == HDLC_FLAG) || (raw_byte == HDLC_ESC));
        final_form = !need_esc;
        if (need_esc) begin
            emit_byte = HDLC_ESC;
        end else if (esc_pend_q) begin
            emit_byte = raw_byte ^ HDLC_ESC_XOR;
        end else begin
            emit_byte = raw_byte;
        end

        ready_in = !rst && ((state_q == ST_IDLE) ||
                   ((state_q == ST_PAYLOAD) && final_form && !hold_eop_q));
        accept   = valid_in && ready_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            hold_q     <= 8'h00;
            hold_eop_q <= 1'b0;
            esc_pend_q <= 1'b0;
            data_fr_q  <= HDLC_FLAG;
            underrun_q <= 1'b0;
        end else begin
            data_fr_q  <= emit_byte;
            esc_pend_q <= need_esc;
            underrun_q <= (state_q == ST_ABORT);
            case (state_q)
                ST_IDLE: begin
                    if (accept && sop_in) begin
                        hold_q     <= data_in;
                        hold_eop_q <= eop_in;
                        state_q    <= ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    if (final_form) begin
                        if (hold_eop_q) begin
`ifdef HDLC_FCS_EN
                            state_q <= ST_FCS_LO;
`else
                            state_q <= ST_CLOSE;
`endif
                        end else if (accept && !sop_in) begin
                            hold_q     <= data_in;
                            hold_eop_q <= eop_in;
                        end else begin
                            state_q <= ST_ABORT;
                        end
                    end
                end
                ST_FCS_LO: begin
                    if (final_form) begin
                        state_q <= ST_FCS_HI;
                    end
                end
                ST_FCS_HI: begin
                    if (final_form) begin
                        state_q <= ST_CLOSE;
                    end
                end
                // The abort's trailing flag reuses the closing-flag state.
                ST_ABORT: state_q <= ST_CLOSE;
                ST_CLOSE: state_q <= ST_IDLE;
                default:  state_q <= ST_IDLE;
            endcase
        end
    end

    assign data_fr  = data_fr_q;
    assign underrun = underrun_q;

endmodule

`default_nettype wire

// File: tb/tb_hdlc_framer.sv
// ============================================================================
// Module   : tb_hdlc_framer
// Purpose  : Self-checking bench for hdlc_framer against a frame-level model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_hdlc_framer;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid_in;
    logic       sop_in;
    logic       eop_in;
    logic [7:0] data_in;
    logic       ready_in;
    logic [7:0] data_fr;
    logic       underrun;

    int n_tests = 0;
    int n_fail  = 0;

    logic       armed = 1'b0;
    logic [7:0] cap_q[$];
    logic       cap_u[$];
    logic [7:0] exp_q[$];
    logic [7:0] pay_q[$];

    hdlc_framer dut (
        .clk      (clk),
        .rst      (rst),
        .valid_in (valid_in),
        .sop_in   (sop_in),
        .eop_in   (eop_in),
        .data_in  (data_in),
        .ready_in (ready_in),
        .data_fr  (data_fr),
        .underrun (underrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (armed) begin
            cap_q.push_back(data_fr);
            cap_u.push_back(underrun);
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

`ifdef HDLC_FCS_EN
    // Bit-serial X.25 FCS over the payload, returned already complemented.
    function automatic logic [15:0] model_fcs();
        logic [15:0] r;
        logic        fb;
        r = 16'hFFFF;
        foreach (pay_q[i]) begin
            for (int k = 0; k < 8; k++) begin
                fb = r[0] ^ pay_q[i][k];
                r  = r >> 1;
                if (fb) r = r ^ 16'h8408;
            end
        end
        return ~r;
    endfunction
`endif

    task automatic push_stuffed(input logic [7:0] b);
        if (b == 8'h7E || b == 8'h7D) begin
            exp_q.push_back(8'h7D);
            exp_q.push_back(b ^ 8'h20);
        end else begin
            exp_q.push_back(b);
        end
    endtask

    // Sends pay_q; if stop_after < size, valid drops after that many bytes.
    task automatic run_frame(input string tag, input int stop_after);
        int n, nsend, idx, cyc, t_sop, t_last, esc, u_idx, w;
        logic full, acc;
`ifdef HDLC_FCS_EN
        logic [15:0] fcs;
`endif
        n     = pay_q.size();
        full  = (stop_after >= n);
        nsend = full ? n : stop_after;
        exp_q.delete();
        cap_q.delete();
        cap_u.delete();
        exp_q.push_back(8'h7E);
        for (int i = 0; i < nsend; i++) push_stuffed(pay_q[i]);
        u_idx = -1;
        if (full) begin
`ifdef HDLC_FCS_EN
            fcs = model_fcs();
            push_stuffed(fcs[7:0]);
            push_stuffed(fcs[15:8]);
`endif
            exp_q.push_back(8'h7E);
        end else begin
            u_idx = exp_q.size();
            exp_q.push_back(8'h7D);
            exp_q.push_back(8'h7E);
        end
        exp_q.push_back(8'h7E);
        exp_q.push_back(8'h7E);

        esc = 0;
        for (int i = 0; i < nsend - 1; i++)
            if (pay_q[i] == 8'h7E || pay_q[i] == 8'h7D) esc++;

        idx = 0; cyc = 0; t_sop = 0; t_last = 0;
        while (idx < nsend && cyc < 200) begin
            valid_in = 1'b1;
            sop_in   = (idx == 0);
            eop_in   = (idx == n - 1);
            data_in  = pay_q[idx];
            @(negedge clk);
            acc = ready_in;
            @(posedge clk);
            #1;
            if (acc) begin
                if (idx == 0) begin
                    armed = 1'b1;
                    t_sop = cyc;
                end
                t_last = cyc;
                idx++;
            end
            cyc++;
        end
        valid_in = 1'b0;
        sop_in   = 1'b0;
        eop_in   = 1'b0;
        check_val({tag, " accepted"}, idx, nsend);
        check_val({tag, " ready_timing"}, t_last - t_sop, nsend - 1 + esc);

        w = 0;
        while (cap_q.size() < exp_q.size() && w < 200) begin
            @(posedge clk);
            w++;
        end
        #1;
        armed = 1'b0;
        check_val({tag, " cap_len"}, (cap_q.size() >= exp_q.size()), 1);
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            check_val($sformatf("%s octet%0d", tag, i), cap_q[i], exp_q[i]);
            check_val($sformatf("%s underrun%0d", tag, i), cap_u[i], (i == u_idx));
        end
    endtask

    task automatic random_payload(input int len);
        int r;
        pay_q.delete();
        for (int i = 0; i < len; i++) begin
            r = $urandom_range(0, 5);
            if (r == 0)      pay_q.push_back(8'h7E);
            else if (r == 1) pay_q.push_back(8'h7D);
            else             pay_q.push_back(8'($urandom_range(0, 255)));
        end
    endtask

    initial begin
        int acc_cnt, guard;
        rst      = 1'b1;
        valid_in = 1'b0;
        sop_in   = 1'b0;
        eop_in   = 1'b0;
        data_in  = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("reset data_fr", data_fr, 8'h7E);
        check_val("reset underrun", underrun, 1'b0);
        check_val("reset ready", ready_in, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_val("idle ready", ready_in, 1'b1);

        // A non-sop byte offered while idle must be dropped.
        valid_in = 1'b1;
        data_in  = 8'h55;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        @(negedge clk);
        check_val("idle drop data_fr", data_fr, 8'h7E);
        @(negedge clk);
        check_val("idle drop data_fr2", data_fr, 8'h7E);
        @(posedge clk);
        #1;

        pay_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        run_frame("check9", 100);
        pay_q = '{8'h7E, 8'h7D, 8'h41};
        run_frame("escapes", 100);
        pay_q = '{8'h00};
        run_frame("single", 100);
        pay_q = '{8'hAA, 8'hBB};
        run_frame("aabb", 100);
        pay_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        run_frame("abort", 3);
        pay_q = '{8'hC0, 8'h7E};
        run_frame("after_abort", 100);

        // Reset pulse mid-payload truncates the frame.
        valid_in = 1'b1;
        acc_cnt  = 0;
        guard    = 0;
        while (acc_cnt < 2 && guard < 50) begin
            sop_in  = (acc_cnt == 0);
            eop_in  = 1'b0;
            data_in = 8'h10 + 8'(acc_cnt);
            @(negedge clk);
            if (ready_in) acc_cnt++;
            @(posedge clk);
            #1;
            guard++;
        end
        check_val("rst_mid accepted", acc_cnt, 2);
        sop_in = 1'b0;
        rst    = 1'b1;
        @(negedge clk);
        check_val("rst_mid ready_low", ready_in, 1'b0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        valid_in = 1'b0;
        @(negedge clk);
        check_val("rst_mid data_fr", data_fr, 8'h7E);
        check_val("rst_mid underrun", underrun, 1'b0);
        check_val("rst_mid ready_high", ready_in, 1'b1);
        @(posedge clk);
        #1;

        for (int f = 0; f < 20; f++) begin
            random_payload($urandom_range(1, 8));
            if ($urandom_range(0, 3) == 0 && pay_q.size() > 1)
                run_frame($sformatf("rnd%0d_abort", f), $urandom_range(1, pay_q.size() - 1));
            else
                run_frame($sformatf("rnd%0d", f), 100);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
